branch_exec_unit: RTL

//  Parametrised branch/jump resolution stage for the npc EX path.
//  - Evaluates all six conditional branches plus JAL/JALR.
//  - Registers the result behind a valid/ready output slot.
//  - Holds a direct-mapped BHT of 2-bit counters, read by IF and updated on

---
 rtl/branch_exec_unit_if.sv | 41 ++++
 rtl/branch_exec_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_exec_unit_if.sv
// Request/result bundle for branch_exec_unit.
//   master : producer of requests, consumer of results (issue side / bench)
//   slave  : the branch unit itself
// Request : in_valid/in_ready handshake plus pc, opcode, func3, operands, imm,
//           fetch-time prediction.
// Result  : out_valid/out_ready handshake plus taken, next_pc, link, mispredict.
// XLEN here must match the XLEN of the branch_exec_unit it is bound to.
interface branch_exec_unit_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [6:0]      in_opcode;
  logic [2:0]      in_func3;
  logic [XLEN-1:0] in_src1;
  logic [XLEN-1:0] in_src2;
  logic [XLEN-1:0] in_imm;
  logic            in_pred_taken;

  logic            out_valid;
  logic            out_ready;
  logic            out_taken;
  logic [XLEN-1:0] out_next_pc;
  logic [XLEN-1:0] out_link;
  logic            out_mispredict;

  modport master (
    output in_valid, in_pc, in_opcode, in_func3, in_src1, in_src2, in_imm, in_pred_taken,
    input  in_ready,
    input  out_valid, out_taken, out_next_pc, out_link, out_mispredict,
    output out_ready
  );

  modport slave (
    input  in_valid, in_pc, in_opcode, in_func3, in_src1, in_src2, in_imm, in_pred_taken,
    output in_ready,
    output out_valid, out_taken, out_next_pc, out_link, out_mispredict,
    input  out_ready
  );
endinterface

// File: rtl/branch_exec_unit.sv
// Branch/jump resolution stage for the EX path.
// Resolves the six conditional branches plus JAL/JALR, registers the result in a
// single valid/ready output slot (latency 1), keeps a direct-mapped BHT of 2-bit
// counters for IF lookups, and counts delivered mispredicts (saturating).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   flush        : redirect; drops the held result and the current request
//   bus          : request/result bundle (slave modport)
//   pred_pc      : IF lookup PC
//   pred_taken   : BHT prediction for pred_pc (combinational, pre-update value)
//   mispred_cnt  : saturating count of mispredicts handed to the consumer
module branch_exec_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  branch_exec_unit_if.slave   bus,
  input  logic [XLEN-1:0]     pred_pc,
  output logic                pred_taken,
  output logic [CNT_W-1:0]    mispred_cnt
);

  localparam int unsigned IdxW = $clog2(BHT_ENTRIES);

  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;

  localparam logic [XLEN-1:0] PcStep   = XLEN'(4);
  localparam logic [XLEN-1:0] JalrMask = {{(XLEN-1){1'b1}}, 1'b0};

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic out_valid_q, out_valid_d;
  logic in_ready;
  logic accept;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready && !flush;

  // ---------------------------------------------------------------------------
  // Compare: one subtractor gives eq, ltu and (with the sign fix-up) lt
  // ---------------------------------------------------------------------------
  logic [XLEN:0] diff;
  logic          eq, lt, ltu;

  assign diff = {1'b0, bus.in_src1} + {1'b0, ~bus.in_src2} + {{XLEN{1'b0}}, 1'b1};
  assign eq   = (diff[XLEN-1:0] == '0);
  assign ltu  = !diff[XLEN];
  // Differing signs: the negative operand is the smaller one.
  assign lt   = (bus.in_src1[XLEN-1] != bus.in_src2[XLEN-1]) ? bus.in_src1[XLEN-1]
                                                             : diff[XLEN-1];

  logic cond_taken;
  always_comb begin
    cond_taken = 1'b0;
    case (bus.in_func3)
      3'd0:    cond_taken = eq;
      3'd1:    cond_taken = !eq;
      3'd4:    cond_taken = lt;
      3'd5:    cond_taken = !lt;
      3'd6:    cond_taken = ltu;
      3'd7:    cond_taken = !ltu;
      default: cond_taken = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Resolution
  // ---------------------------------------------------------------------------
  logic            is_branch;
  logic            res_taken;
  logic            res_mis;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] res_target;
  logic [XLEN-1:0] res_next_pc;

  assign is_branch = (bus.in_opcode == OpBranch);
  assign pc_plus4  = bus.in_pc + PcStep;

  always_comb begin
    res_taken  = 1'b0;
    res_mis    = 1'b0;
    res_target = bus.in_pc + bus.in_imm;
    case (bus.in_opcode)
      OpBranch: begin
        res_taken = cond_taken;
        res_mis   = cond_taken != bus.in_pred_taken;
      end
      OpJal: begin
        res_taken = 1'b1;
        res_mis   = !bus.in_pred_taken;
      end
      OpJalr: begin
        res_taken  = 1'b1;
        res_target = (bus.in_src1 + bus.in_imm) & JalrMask;
        // The target register is never predicted, so JALR always redirects.
        res_mis    = 1'b1;
      end
      default: begin
        res_taken = 1'b0;
        res_mis   = 1'b0;
      end
    endcase
  end

  assign res_next_pc = res_taken ? res_target : pc_plus4;

  // ---------------------------------------------------------------------------
  // Output slot
  // ---------------------------------------------------------------------------
  logic            out_taken_q;
  logic            out_mis_q;
  logic [XLEN-1:0] out_next_pc_q;
  logic [XLEN-1:0] out_link_q;

  always_comb begin
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_taken_q   <= 1'b0;
      out_mis_q     <= 1'b0;
      out_next_pc_q <= '0;
      out_link_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (accept) begin
        out_taken_q   <= res_taken;
        out_mis_q     <= res_mis;
        out_next_pc_q <= res_next_pc;
        out_link_q    <= pc_plus4;
      end
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_taken      = out_taken_q;
  assign bus.out_next_pc    = out_next_pc_q;
  assign bus.out_link       = out_link_q;
  assign bus.out_mispredict = out_mis_q;

  // ---------------------------------------------------------------------------
  // BHT: 2-bit saturating counters, reset to weakly not-taken
  // ---------------------------------------------------------------------------
  logic [1:0]      bht_q [BHT_ENTRIES];
  logic [IdxW-1:0] wr_idx;
  logic [IdxW-1:0] rd_idx;
  logic [1:0]      wr_old;
  logic [1:0]      wr_new;
  logic            bht_we;

  assign wr_idx = bus.in_pc[IdxW+1:2];
  assign rd_idx = pred_pc[IdxW+1:2];
  assign wr_old = bht_q[wr_idx];
  assign bht_we = accept && is_branch;

  always_comb begin
    wr_new = wr_old;
    if (cond_taken) begin
      if (wr_old != 2'b11) wr_new = wr_old + 2'b01;
    end else begin
      if (wr_old != 2'b00) wr_new = wr_old - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
        bht_q[i] <= 2'b01;
      end
    end else if (bht_we) begin
      bht_q[wr_idx] <= wr_new;
    end
  end

  // Read straight from the array, so a same-cycle write is not visible yet.
  assign pred_taken = bht_q[rd_idx][1];

  logic unused_pred_pc_bits;
  assign unused_pred_pc_bits = ^{pred_pc[XLEN-1:IdxW+2], pred_pc[1:0]};

  // ---------------------------------------------------------------------------
  // Mispredict counter: counts results actually handed over
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid_q && bus.out_ready && out_mis_q && !flush && (cnt_q != '1)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign mispred_cnt = cnt_q;

endmodule
